mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  XM23 data-memory stage, directly downstream of the alu/update_psw execute stage.
//  Accepts one LD/ST request per handshake and computes the effective address (pre/post, inc/dec).
//  Drives the synchronous d_ram (1-cycle read latency, word-addressed) and returns load data and
//  the updated address register to the pipeline_registers writeback path.
//  Holds busy toward pipeline_controller while a request is in flight.
// PARAMETERS
//  ADDR_W  16  byte-address width
//  RAM_AW  15  d_ram word-address width (= ADDR_W-1)
// PORTS
//  clk          in   1       stage clock (divided clk, same as pipeline_registers)
//  reset        in   1       asynchronous, active-high
//  req_valid    in   1       request present this cycle
//  req_ready    out  1       stage can accept (state==IDLE)
//  is_load      in   1       1=LD, 0=ST
//  wb_byte      in   1       WB bit: 0=word, 1=byte
//  prpo         in   1       1=pre-modify, 0=post-modify
//  dec, inc     in   1 each  address decrement / increment
//  base_addr    in   16      address register value
//  base_reg     in   3       address register number
//  st_data      in   16      store source value
//  dst_reg      in   3       load destination register
//  dst_old      in   16      current Rd value (for byte-load merge)
//  ram_addr     out  RAM_AW  d_ram word address
//  ram_wdata    out  16      d_ram write data
//  ram_be       out  2       byte enables ([0]=low byte)
//  ram_wren     out  1       d_ram write enable
//  ram_q        in   16      d_ram read data, valid 1 clk after address
//  ld_wb_valid  out  1       1-cycle pulse: ld_wb_reg <= ld_wb_data
//  ld_wb_reg    out  3
//  ld_wb_data   out  16
//  ar_wb_valid  out  1       1-cycle pulse: ar_wb_reg <= ar_wb_data
//  ar_wb_reg    out  3
//  ar_wb_data   out  16
//  busy         out  1       = !req_ready, to pipeline_controller stall logic
//  fault        out  1       1-cycle pulse: request rejected (misaligned / inc&dec)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, except req_ready=1. Any in-flight access is dropped;
//    ram_wren falls immediately.
//  amt = wb_byte ? 1 : 2. mod = base_addr + amt (inc), - amt (dec), else base_addr; mod16 wraps.
//  eff = prpo ? mod : base_addr. Address writeback occurs iff inc|dec.
//  Accept when req_valid && req_ready; operands are registered on that edge (E0).
//  Faults: (inc && dec), or (!wb_byte && eff[0]). Then fault=1 for one cycle after E0,
//    no RAM access, no writebacks, and state stays IDLE.
//  States: IDLE -> ACCESS -> IDLE for stores; IDLE -> ACCESS -> LWAIT -> IDLE for loads.
//  ACCESS (cycle after E0):
//    ram_addr = eff[15:1].
//    Store word: ram_be=11, wdata=st_data.
//    Store byte: eff[0]=0 -> be=01, wdata={8'h0,st_data[7:0]}; eff[0]=1 -> be=10,
//      wdata={st_data[7:0],8'h0}.
//    ram_wren=is_store only in ACCESS. ar_wb_valid pulses on exiting ACCESS (E1), ar_wb_data=mod.
//  LWAIT: ram_q valid. On exit (E2), ld_wb_valid pulses for one cycle.
//    Word load: data=ram_q.
//    Byte load: data={dst_old_reg[15:8], eff[0]?q[15:8]:q[7:0]}; Rd high byte is preserved.
//  Latency from E0: store write at E1, 1 busy cycle; load data at E2, 2 busy cycles.
//  Next request is accepted at earliest on the edge ending the final state (back-to-back
//    stores: one per 2 clk).
//  ar_wb and ld_wb to the same register (LD with inc/dec, base_reg==dst_reg): ld_wb wins.
//    The stage suppresses ar_wb_valid in that case.
//  Little-endian: byte address 2k = low byte of word k. Address 0xFFFF post-inc wraps to 0x0000.
// TESTING
//  ST word, base=0x1000, data=0xBEEF, no inc/dec -> E1: ram_addr=0x0800, be=11, wren=1;
//    no ar_wb pulse.
//  LD.B pre-dec, base=0x2001, mem[0x1000]=0x12AB, dst_old=0x5555 -> ar_wb=0x2000,
//    ld_wb_data=0x55AB at E2.
//  LD word post-inc, base=0xFFFE, base_reg=R2, dst_reg=R3 -> read word 0x7FFF;
//    ar_wb R2=0x0000 at E1; ld_wb R3 at E2.
//  LD word, base=0x0101 -> fault pulse; no wren, no writebacks; req_ready stays 1.
//  Reset asserted during LWAIT -> all outputs 0 asynchronously, req_ready=1; no ld_wb pulse follows.
//  Two stores held with req_valid=1 -> second accepted exactly 2 clk after first; busy=1 between.

Source files
------------

// File: rtl/mem_access_stage.sv
// XM23 data-memory stage: one LD/ST per handshake, effective-address
// generation with pre/post inc/dec, synchronous d_ram access, and
// load / address-register writeback pulses toward the register file.
module mem_access_stage #(
  parameter int ADDR_W = 16,
  parameter int RAM_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_load,
  input  logic              wb_byte,
  input  logic              prpo,
  input  logic              dec,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [2:0]        base_reg,
  input  logic [15:0]       st_data,
  input  logic [2:0]        dst_reg,
  input  logic [15:0]       dst_old,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic [1:0]        ram_be,
  output logic              ram_wren,
  input  logic [15:0]       ram_q,
  output logic              ld_wb_valid,
  output logic [2:0]        ld_wb_reg,
  output logic [15:0]       ld_wb_data,
  output logic              ar_wb_valid,
  output logic [2:0]        ar_wb_reg,
  output logic [ADDR_W-1:0] ar_wb_data,
  output logic              busy,
  output logic              fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    LWAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Captured request (data only, no reset needed: every use is gated by state)
  logic              r_is_load;
  logic              r_wb_byte;
  logic              r_ar_en;
  logic [ADDR_W-1:0] r_eff;
  logic [ADDR_W-1:0] r_mod;
  logic [2:0]        r_base_reg;
  logic [2:0]        r_dst_reg;
  logic [15:0]       r_st_data;
  logic [15:0]       r_dst_old;
  logic              r_fault;

  logic [ADDR_W-1:0] w_amt;
  logic [ADDR_W-1:0] w_mod;
  logic [ADDR_W-1:0] w_eff;
  logic              w_fault;
  logic              w_accept;
  logic              w_ar_suppress;

  // Byte loads replace only the low byte of Rd; the lane comes from eff[0].
  function automatic logic [15:0] load_merge(input logic        byte_mode,
                                             input logic        odd,
                                             input logic [15:0] q,
                                             input logic [15:0] old);
    logic [7:0] lane;
    lane = odd ? q[15:8] : q[7:0];
    return byte_mode ? {old[15:8], lane} : q;
  endfunction

  assign w_amt    = wb_byte ? ADDR_W'(1) : ADDR_W'(2);
  assign w_mod    = inc ? (base_addr + w_amt) : (dec ? (base_addr - w_amt) : base_addr);
  assign w_eff    = prpo ? w_mod : base_addr;
  assign w_fault  = (inc && dec) || (!wb_byte && w_eff[0]);
  assign w_accept = req_valid && (r_state == IDLE);

  // A load that also updates its own destination register: load data wins.
  assign w_ar_suppress = r_is_load && (r_base_reg == r_dst_reg);

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign fault     = r_fault;

  // Control state: FSM register and the one-cycle fault pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fault <= w_accept && w_fault;
    end
  end

  // E0: register the request operands and the precomputed addresses
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_load  <= is_load;
      r_wb_byte  <= wb_byte;
      r_ar_en    <= inc | dec;
      r_eff      <= w_eff;
      r_mod      <= w_mod;
      r_base_reg <= base_reg;
      r_dst_reg  <= dst_reg;
      r_st_data  <= st_data;
      r_dst_old  <= dst_old;
    end
  end

  // Next state plus all RAM and writeback outputs, decoded from the state
  always_comb begin
    w_next      = r_state;
    ram_addr    = '0;
    ram_wdata   = '0;
    ram_be      = '0;
    ram_wren    = 1'b0;
    ld_wb_valid = 1'b0;
    ld_wb_reg   = '0;
    ld_wb_data  = '0;
    ar_wb_valid = 1'b0;
    ar_wb_reg   = '0;
    ar_wb_data  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_fault) w_next = ACCESS;
      end
      ACCESS: begin
        w_next   = r_is_load ? LWAIT : IDLE;
        ram_addr = r_eff[ADDR_W-1:1];
        if (!r_is_load) begin
          ram_wren = 1'b1;
          if (!r_wb_byte) begin
            ram_be    = 2'b11;
            ram_wdata = r_st_data;
          end else if (r_eff[0]) begin
            ram_be    = 2'b10;
            ram_wdata = {r_st_data[7:0], 8'h00};
          end else begin
            ram_be    = 2'b01;
            ram_wdata = {8'h00, r_st_data[7:0]};
          end
        end
        if (r_ar_en && !w_ar_suppress) begin
          ar_wb_valid = 1'b1;
          ar_wb_reg   = r_base_reg;
          ar_wb_data  = r_mod;
        end
      end
      LWAIT: begin
        w_next      = IDLE;
        ld_wb_valid = 1'b1;
        ld_wb_reg   = r_dst_reg;
        ld_wb_data  = load_merge(r_wb_byte, r_eff[0], ram_q, r_dst_old);
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a behavioural d_ram
// (1-cycle read latency, byte-enabled writes).
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        wb_byte;
  logic        prpo;
  logic        dec;
  logic        inc;
  logic [15:0] base_addr;
  logic [2:0]  base_reg;
  logic [15:0] st_data;
  logic [2:0]  dst_reg;
  logic [15:0] dst_old;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [1:0]  ram_be;
  logic        ram_wren;
  logic [15:0] ram_q;
  logic        ld_wb_valid;
  logic [2:0]  ld_wb_reg;
  logic [15:0] ld_wb_data;
  logic        ar_wb_valid;
  logic [2:0]  ar_wb_reg;
  logic [15:0] ar_wb_data;
  logic        busy;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem [0:32767];

  mem_access_stage #(.ADDR_W(16), .RAM_AW(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .wb_byte(wb_byte), .prpo(prpo), .dec(dec), .inc(inc),
    .base_addr(base_addr), .base_reg(base_reg), .st_data(st_data),
    .dst_reg(dst_reg), .dst_old(dst_old),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_wren(ram_wren), .ram_q(ram_q),
    .ld_wb_valid(ld_wb_valid), .ld_wb_reg(ld_wb_reg), .ld_wb_data(ld_wb_data),
    .ar_wb_valid(ar_wb_valid), .ar_wb_reg(ar_wb_reg), .ar_wb_data(ar_wb_data),
    .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) begin
      if (ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
      if (ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
    end
    ram_q <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic ld, input logic bw, input logic pp, input logic dc,
                     input logic ic, input logic [15:0] ba, input logic [2:0] br,
                     input logic [15:0] sd, input logic [2:0] dr, input logic [15:0] dold);
    req_valid = 1'b1;
    is_load   = ld;
    wb_byte   = bw;
    prpo      = pp;
    dec       = dc;
    inc       = ic;
    base_addr = ba;
    base_reg  = br;
    st_data   = sd;
    dst_reg   = dr;
    dst_old   = dold;
  endtask

  initial begin
    reset = 1'b1;
    req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 16'h0, 3'd0, 16'h0);
    req_valid = 1'b0;
    tick();
    chk("rst_ready", req_ready, 16'd1);
    chk("rst_busy", busy, 16'd0);
    chk("rst_wren", ram_wren, 16'd0);
    chk("rst_fault", fault, 16'd0);
    chk("rst_ldv", ld_wb_valid, 16'd0);
    chk("rst_arv", ar_wb_valid, 16'd0);
    reset = 1'b0;
    tick();

    // ST word 0x1000 <- 0xBEEF, no address update
    req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 3'd1, 16'hBEEF, 3'd0, 16'h0);
    chk("stw_ready_pre", req_ready, 16'd1);
    tick();
    req_valid = 1'b0;
    chk("stw_addr", ram_addr, 16'h0800);
    chk("stw_be", ram_be, 16'h3);
    chk("stw_wren", ram_wren, 16'd1);
    chk("stw_wdata", ram_wdata, 16'hBEEF);
    chk("stw_arv", ar_wb_valid, 16'd0);
    chk("stw_busy", busy, 16'd1);
    chk("stw_ready", req_ready, 16'd0);
    tick();
    chk("stw_wren_off", ram_wren, 16'd0);
    chk("stw_ready_post", req_ready, 16'd1);

    // Preload word 0x1000 = 0x12AB and word 0x7FFF = 0xCAFE via stores
    req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2000, 3'd0, 16'h12AB, 3'd0, 16'h0);
    tick();
    req_valid = 1'b0;
    chk("pre1_addr", ram_addr, 16'h1000);
    tick();
    req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFE, 3'd0, 16'hCAFE, 3'd0, 16'h0);
    tick();
    req_valid = 1'b0;
    chk("pre2_addr", ram_addr, 16'h7FFF);
    tick();

    // LD.B pre-dec 0x2001 -> eff 0x2000, low byte of 0x12AB merged into 0x5555
    req(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h2001, 3'd1, 16'h0, 3'd4, 16'h5555);
    tick();
    req_valid = 1'b0;
    chk("ldb_addr", ram_addr, 16'h1000);
    chk("ldb_wren", ram_wren, 16'd0);
    chk("ldb_arv", ar_wb_valid, 16'd1);
    chk("ldb_arreg", ar_wb_reg, 16'd1);
    chk("ldb_ardata", ar_wb_data, 16'h2000);
    chk("ldb_ldv_early", ld_wb_valid, 16'd0);
    tick();
    chk("ldb_ldv", ld_wb_valid, 16'd1);
    chk("ldb_ldreg", ld_wb_reg, 16'd4);
    chk("ldb_lddata", ld_wb_data, 16'h55AB);
    chk("ldb_arv_off", ar_wb_valid, 16'd0);
    chk("ldb_busy", busy, 16'd1);
    tick();
    chk("ldb_ldv_off", ld_wb_valid, 16'd0);
    chk("ldb_ready", req_ready, 16'd1);

    // LD word post-inc 0xFFFE: R2 wraps to 0x0000, R3 gets 0xCAFE
    req(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 3'd2, 16'h0, 3'd3, 16'h0);
    tick();
    req_valid = 1'b0;
    chk("ldw_addr", ram_addr, 16'h7FFF);
    chk("ldw_arv", ar_wb_valid, 16'd1);
    chk("ldw_arreg", ar_wb_reg, 16'd2);
    chk("ldw_ardata", ar_wb_data, 16'h0000);
    tick();
    chk("ldw_ldv", ld_wb_valid, 16'd1);
    chk("ldw_ldreg", ld_wb_reg, 16'd3);
    chk("ldw_lddata", ld_wb_data, 16'hCAFE);
    tick();

    // LD post-inc with base_reg == dst_reg: address writeback suppressed
    req(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1000, 3'd5, 16'h0, 3'd5, 16'h0);
    tick();
    req_valid = 1'b0;
    chk("sup_arv", ar_wb_valid, 16'd0);
    tick();
    chk("sup_ldv", ld_wb_valid, 16'd1);
    chk("sup_lddata", ld_wb_data, 16'hBEEF);
    tick();

    // Misaligned word load: fault pulse, no access
    req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 3'd1, 16'h0, 3'd2, 16'h0);
    tick();
    req_valid = 1'b0;
    chk("mis_fault", fault, 16'd1);
    chk("mis_ready", req_ready, 16'd1);
    chk("mis_wren", ram_wren, 16'd0);
    chk("mis_arv", ar_wb_valid, 16'd0);
    tick();
    chk("mis_fault_off", fault, 16'd0);
    chk("mis_ldv", ld_wb_valid, 16'd0);

    // inc && dec together: fault
    req(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4000, 3'd1, 16'h0011, 3'd0, 16'h0);
    tick();
    req_valid = 1'b0;
    chk("incdec_fault", fault, 16'd1);
    chk("incdec_wren", ram_wren, 16'd0);
    tick();

    // Back-to-back byte stores to odd address 0x3001, req_valid held
    req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3001, 3'd1, 16'h00A5, 3'd0, 16'h0);
    tick();
    chk("b2b_busy1", busy, 16'd1);
    chk("b2b_addr", ram_addr, 16'h1800);
    chk("b2b_be", ram_be, 16'h2);
    chk("b2b_wdata", ram_wdata, 16'hA500);
    tick();
    chk("b2b_gap_ready", req_ready, 16'd1);
    chk("b2b_gap_wren", ram_wren, 16'd0);
    tick();
    req_valid = 1'b0;
    chk("b2b_busy2", busy, 16'd1);
    chk("b2b_wren2", ram_wren, 16'd1);
    tick();

    // Byte store to even address 0x3000: low lane only
    req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 3'd1, 16'h12C3, 3'd0, 16'h0);
    tick();
    req_valid = 1'b0;
    chk("stbe_be", ram_be, 16'h1);
    chk("stbe_wdata", ram_wdata, 16'h00C3);
    tick();
    req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3000, 3'd1, 16'h0, 3'd6, 16'h0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("merge_lddata", ld_wb_data, 16'hA5C3);
    tick();

    // Byte store post-inc at 0xFFFF: high lane, address wraps to 0x0000
    req(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 3'd7, 16'h0077, 3'd0, 16'h0);
    tick();
    req_valid = 1'b0;
    chk("wrap_addr", ram_addr, 16'h7FFF);
    chk("wrap_be", ram_be, 16'h2);
    chk("wrap_wdata", ram_wdata, 16'h7700);
    chk("wrap_arv", ar_wb_valid, 16'd1);
    chk("wrap_ardata", ar_wb_data, 16'h0000);
    tick();

    // Reset asserted during LWAIT
    req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 3'd1, 16'h0, 3'd6, 16'h0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("rlw_ldv_pre", ld_wb_valid, 16'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rlw_ldv", ld_wb_valid, 16'd0);
    chk("rlw_lddata", ld_wb_data, 16'h0000);
    chk("rlw_ready", req_ready, 16'd1);
    chk("rlw_busy", busy, 16'd0);
    #1;
    reset = 1'b0;
    tick();
    chk("rlw_ldv_after", ld_wb_valid, 16'd0);
    chk("rlw_ready_after", req_ready, 16'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
